prbs_pattern_gen: RTL and testbench

Transmit-side companion to the pattern detector in the PRBS-15 link test path. On a start request it emits a fixed 32-bit header pattern, one byte per clock, a programmable number of times. It then emits a programmable number of PRBS-15 payload bytes on the same 8-bit bus and signals completion. Its byte stream is the stimulus the receive-side detector checks.

---
 rtl/prbs_pattern_gen.sv | 174 +++++++++++++++++
 tb/tb_prbs_pattern_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/prbs_pattern_gen.sv
// Header-plus-PRBS-15 byte stream generator for the link test path.
// Optional build macro GEN_ERR_INJECT_EN adds a one-shot header error injector on err_inject.
module prbs_pattern_gen #(
    parameter logic [31:0] PATTERN   = 32'hABCDEF23,
    parameter logic [14:0] PRBS_SEED = 15'h7FFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] n_pattern,
    input  logic [7:0] n_prbs,
`ifdef GEN_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    output logic [7:0] out_PRBS,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PRBS = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  byte_idx_r;
    logic [7:0]  rep_cnt_r;
    logic [7:0]  prbs_cnt_r;
    logic [7:0]  n_pattern_r;
    logic [7:0]  n_prbs_r;
    logic [14:0] lfsr_r;

    logic [22:0] prbs_s;
    logic [7:0]  hdr_byte_s;
    logic [7:0]  hdr_err_s;
    logic        hdr_last_s;
    logic        prbs_last_s;

    // Eight x^15+x^14+1 steps; returns {next_state, byte} with the first bit in byte[7].
    function automatic logic [22:0] prbs_byte(input logic [14:0] state);
        logic [14:0] l;
        logic [7:0]  b;
        logic        fb;
        l = state;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            fb = l[14] ^ l[13];
            l  = {l[13:0], fb};
            b  = {b[6:0], fb};
        end
        return {l, b};
    endfunction

`ifdef GEN_ERR_INJECT_EN
    logic armed_r;

    // One-shot injection flag: consumed by the next header byte, re-armed by any pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_r <= 1'b0;
        end else if ((state_r == ST_HDR) && armed_r) begin
            armed_r <= err_inject;
        end else begin
            armed_r <= armed_r | err_inject;
        end
    end

    // Error mask applied to header bytes.
    always_comb begin
        hdr_err_s = 8'h00;
        if (armed_r) begin
            hdr_err_s = 8'h01;
        end else begin
            hdr_err_s = 8'h00;
        end
    end
`else
    // No injection in this build.
    always_comb begin
        hdr_err_s = 8'h00;
    end
`endif

    // Next-byte selection and end-of-phase detection.
    always_comb begin
        prbs_s      = prbs_byte(lfsr_r);
        hdr_last_s  = (byte_idx_r == 2'd3) && (rep_cnt_r == (n_pattern_r - 8'd1));
        prbs_last_s = (prbs_cnt_r == (n_prbs_r - 8'd1));
        case (byte_idx_r)
            2'd0:    hdr_byte_s = PATTERN[31:24];
            2'd1:    hdr_byte_s = PATTERN[23:16];
            2'd2:    hdr_byte_s = PATTERN[15:8];
            2'd3:    hdr_byte_s = PATTERN[7:0];
            default: hdr_byte_s = 8'h00;
        endcase
    end

    // Sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            byte_idx_r  <= 2'd0;
            rep_cnt_r   <= 8'd0;
            prbs_cnt_r  <= 8'd0;
            n_pattern_r <= 8'd0;
            n_prbs_r    <= 8'd0;
            lfsr_r      <= PRBS_SEED;
            out_PRBS    <= 8'h00;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        n_pattern_r <= n_pattern;
                        n_prbs_r    <= n_prbs;
                        lfsr_r      <= PRBS_SEED;
                        byte_idx_r  <= 2'd0;
                        rep_cnt_r   <= 8'd0;
                        prbs_cnt_r  <= 8'd0;
                        if (n_pattern != 8'd0) begin
                            state_r <= ST_HDR;
                        end else if (n_prbs != 8'd0) begin
                            state_r <= ST_PRBS;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_HDR: begin
                    out_PRBS   <= hdr_byte_s ^ hdr_err_s;
                    out_valid  <= 1'b1;
                    busy       <= 1'b1;
                    byte_idx_r <= byte_idx_r + 2'd1;
                    if (byte_idx_r == 2'd3) begin
                        if (hdr_last_s) begin
                            state_r <= (n_prbs_r != 8'd0) ? ST_PRBS : ST_DONE;
                        end else begin
                            rep_cnt_r <= rep_cnt_r + 8'd1;
                        end
                    end
                end
                ST_PRBS: begin
                    out_PRBS   <= prbs_s[7:0];
                    lfsr_r     <= prbs_s[22:8];
                    out_valid  <= 1'b1;
                    busy       <= 1'b1;
                    prbs_cnt_r <= prbs_cnt_r + 8'd1;
                    if (prbs_last_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Directed and randomized checks of prbs_pattern_gen against a recurrence-based stream model.
module tb_prbs_pattern_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] n_pattern;
    logic [7:0] n_prbs;
    logic [7:0] out_PRBS;
    logic       out_valid;
    logic       busy;
    logic       done;
`ifdef GEN_ERR_INJECT_EN
    logic       err_inject;
`endif

    int         total;
    int         bad;
    logic [7:0] last_out;
    logic [7:0] exp_q[$];

    prbs_pattern_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_pattern (n_pattern),
        .n_prbs    (n_prbs),
`ifdef GEN_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .out_PRBS  (out_PRBS),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stream: header bytes, then PRBS bytes from the bit recurrence h[n] = h[n-15] ^ h[n-14].
    task automatic build(input int np, input int nb);
        logic [31:0] pat;
        logic [14:0] seed;
        bit          h[$];
        logic [7:0]  b;
        pat  = 32'hABCDEF23;
        seed = 15'h7FFF;
        exp_q.delete();
        for (int r = 0; r < np; r++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(pat[31 - 8 * k -: 8]);
        for (int k = 0; k < 15; k++) h.push_back(seed[14 - k]);
        for (int n = 15; n < 15 + 8 * nb; n++) h.push_back(h[n - 15] ^ h[n - 14]);
        for (int j = 0; j < nb; j++) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], h[15 + 8 * j + k]};
            exp_q.push_back(b);
        end
    endtask

    task automatic go(input int np, input int nb, input bit b2b, input bit disturb);
        if (!b2b) @(negedge clk);
        start     = 1'b1;
        n_pattern = np[7:0];
        n_prbs    = nb[7:0];
        build(np, nb);
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd0);
        chk("accept_valid", {31'd0, out_valid}, 32'd0);
        chk("accept_done", {31'd0, done}, 32'd0);
        chk("idle_hold", {24'd0, out_PRBS}, {24'd0, last_out});
        for (int i = 0; i < exp_q.size(); i++) begin
            if (disturb && i == 1) begin
                start     = 1'b1;
                n_pattern = 8'd9;
                n_prbs    = 8'd40;
            end
            if (disturb && i == 2) start = 1'b0;
            @(negedge clk);
            chk("valid", {31'd0, out_valid}, 32'd1);
            chk("busy", {31'd0, busy}, 32'd1);
            chk("done_early", {31'd0, done}, 32'd0);
            chk("byte", {24'd0, out_PRBS}, {24'd0, exp_q[i]});
            last_out = exp_q[i];
        end
        @(negedge clk);
        chk("done", {31'd0, done}, 32'd1);
        chk("done_valid", {31'd0, out_valid}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_hold", {24'd0, out_PRBS}, {24'd0, last_out});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        last_out  = 8'h00;
        rst       = 1'b0;
        start     = 1'b0;
        n_pattern = 8'd0;
        n_prbs    = 8'd0;
`ifdef GEN_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        #12;
        chk("rst_out", {24'd0, out_PRBS}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        go(1, 0, 1'b0, 1'b0);
        go(3, 2, 1'b0, 1'b0);
        go(0, 0, 1'b0, 1'b0);
        go(2, 3, 1'b0, 1'b1);
        go(2, 1, 1'b1, 1'b0);
        go(0, 5, 1'b1, 1'b0);

        // Abort during the second header byte.
        @(negedge clk);
        start     = 1'b1;
        n_pattern = 8'd2;
        n_prbs    = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_b0", {24'd0, out_PRBS}, 32'hAB);
        @(negedge clk);
        chk("abort_b1", {24'd0, out_PRBS}, 32'hCD);
        rst = 1'b0;
        #1;
        chk("abort_out", {24'd0, out_PRBS}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("abort_hold_out", {24'd0, out_PRBS}, 32'd0);
        chk("abort_hold_done", {31'd0, done}, 32'd0);
        rst      = 1'b1;
        last_out = 8'h00;
        @(negedge clk);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        go(1, 3, 1'b1, 1'b0);

        for (int r = 0; r < 5; r++)
            go(int'($urandom_range(0, 3)), int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)), 1'b0);

        go(255, 0, 1'b0, 1'b0);
        go(0, 255, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
